// File: rtl/mem_access_unit.sv
// Memory-stage access unit: lane alignment, byte enables, load extension and
// misalignment checking in front of a req/ack data bus with a timeout.
module mem_access_unit #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    typedef struct packed {
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             is_read;
        logic             ld_sign;
        logic [1:0]       ld_size;
        logic [1:0]       ld_offset;
        logic             timed_out;
        logic             busy;
        logic             done;
        logic             err;
        logic [31:0]      rdata;
        logic             bus_req;
        logic             bus_we;
        logic [31:0]      bus_addr;
        logic [3:0]       bus_be;
        logic [31:0]      bus_wdata;
    } regs_t;

    regs_t r, r_nxt;

    logic        misaligned;
    logic        illegal;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] lane;
    logic [31:0] load_ext;

    assign misaligned = ((size == SZ_HALF) && addr[0]) ||
                        ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    assign illegal    = (size == SZ_ILL) || (mem_read && mem_write) || misaligned;

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
        case (size)
            SZ_BYTE: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be_calc    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // The addressed lane is shifted down to bit 0 before extension.
    assign lane = bus_rdata >> {r.ld_offset, 3'b000};

    always_comb begin
        case (r.ld_size)
            SZ_BYTE: load_ext = {{24{r.ld_sign & lane[7]}}, lane[7:0]};
            SZ_HALF: load_ext = {{16{r.ld_sign & lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        // NOTE: start from the held value and clear the pulses so every path assigns every field (no latches).
        r_nxt      = r;
        r_nxt.done = 1'b0;
        r_nxt.err  = 1'b0;
        case (r.state)
            IDLE: begin
                if (start && (mem_read || mem_write)) begin
                    if (illegal) begin
                        r_nxt.done = 1'b1;
                        r_nxt.err  = 1'b1;
                    end else begin
                        r_nxt.state     = BUS;
                        r_nxt.busy      = 1'b1;
                        r_nxt.bus_req   = 1'b1;
                        r_nxt.bus_we    = mem_write;
                        r_nxt.bus_addr  = {addr[31:2], 2'b00};
                        r_nxt.bus_be    = be_calc;
                        r_nxt.bus_wdata = wdata_calc;
                        r_nxt.cnt       = '0;
                        r_nxt.is_read   = mem_read;
                        r_nxt.ld_sign   = sign_ext;
                        r_nxt.ld_size   = size;
                        r_nxt.ld_offset = addr[1:0];
                        r_nxt.timed_out = 1'b0;
                    end
                end
            end
            BUS: begin
                if (bus_ack) begin
                    r_nxt.bus_req = 1'b0;
                    r_nxt.state   = RESP;
                    if (r.is_read) r_nxt.rdata = load_ext;
                end else if (r.cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    r_nxt.bus_req   = 1'b0;
                    r_nxt.timed_out = 1'b1;
                    r_nxt.state     = RESP;
                end else begin
                    r_nxt.cnt = r.cnt + CNT_W'(1);
                end
            end
            RESP: begin
                r_nxt.done  = 1'b1;
                r_nxt.err   = r.timed_out;
                r_nxt.busy  = 1'b0;
                r_nxt.state = IDLE;
            end
            default: r_nxt.state = IDLE;
        endcase
    end

    // NOTE: every output is a register, so an asynchronous reset drops bus_req at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r <= '0;
        else        r <= r_nxt;
    end

    assign busy      = r.busy;
    assign done      = r.done;
    assign err       = r.err;
    assign rdata     = r.rdata;
    assign bus_req   = r.bus_req;
    assign bus_we    = r.bus_we;
    assign bus_addr  = r.bus_addr;
    assign bus_be    = r.bus_be;
    assign bus_wdata = r.bus_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed scenarios plus randomized
// accesses, checked by a monitor against a transaction-level reference model.
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, mem_read, mem_write, sign_ext, bus_ack;
    logic [1:0]  size;
    logic [31:0] addr, wdata, bus_rdata;
    logic        busy, done, err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    mem_access_unit #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read),
        .mem_write(mem_write), .size(size), .sign_ext(sign_ext), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          len;
    } bus_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          edge_n;
    } done_t;

    bus_t        bus_exp[$];
    done_t       done_exp[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] model_rdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model, written directly from the lane/extension rules.
    function automatic logic [3:0] exp_be(input logic [1:0] sz, input int o);
        if (sz == 2'b10) return 4'(1 << o);
        if (sz == 2'b01) return (o == 0) ? 4'b0011 : 4'b1100;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'b10) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sx, input int o,
                                             input logic [31:0] brd);
        logic [31:0] v;
        v = brd >> (8 * o);
        if (sz == 2'b10) begin
            v = v & 32'hFF;
            if (sx && (v & 32'h80) != 0) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = v & 32'hFFFF;
            if (sx && (v & 32'h8000) != 0) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a bus request or a completion.
    initial begin
        bus_t  cur;
        done_t d;
        bit    in_tx = 0;
        int    len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_tx = 0;
            end else begin
                if (err) check("err_implies_done", 32'(done), 32'd1);
                if (bus_req) begin
                    if (!in_tx) begin
                        if (bus_exp.size() == 0) begin
                            check("unexpected_bus_req", 32'(bus_req), 32'd0);
                        end else begin
                            cur   = bus_exp.pop_front();
                            in_tx = 1;
                            len   = 0;
                        end
                    end
                    if (in_tx) begin
                        len++;
                        check("bus_we", 32'(bus_we), 32'(cur.we));
                        check("bus_addr", bus_addr, cur.addr);
                        check("bus_be", 32'(bus_be), 32'(cur.be));
                        if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
                        check("busy_in_bus", 32'(busy), 32'd1);
                    end
                end else if (in_tx) begin
                    check("bus_req_len", 32'(len), 32'(cur.len));
                    in_tx = 0;
                end
                if (done) begin
                    if (done_exp.size() == 0) begin
                        check("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        d = done_exp.pop_front();
                        check("done_err", 32'(err), 32'(d.err));
                        check("done_rdata", rdata, d.rdata);
                        check("done_edge", 32'(cyc), 32'(d.edge_n));
                    end
                end
            end
        end
    end

    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                             input int dly, input bit never_ack, input bit extra);
        bit    active, ok;
        int    o, t;
        bus_t  b;
        done_t d;
        active = rd || wr;
        o      = int'(a[1:0]);
        ok     = active && !(rd && wr) && sz != 2'b11 &&
                 !(sz == 2'b01 && (a % 2) != 0) && !(sz == 2'b00 && (a % 4) != 0);
        @(posedge clk); #1;
        if (active) begin
            if (ok) begin
                b.we    = wr;
                b.addr  = a - 32'(o);
                b.be    = exp_be(sz, o);
                b.wdata = exp_wdata(sz, wd);
                b.len   = never_ack ? TIMEOUT : dly + 1;
                bus_exp.push_back(b);
                if (rd && !never_ack) model_rdata = exp_load(sz, sx, o, brd);
                d.err    = never_ack;
                d.rdata  = model_rdata;
                d.edge_n = cyc + 1 + b.len + 1;
            end else begin
                d.err    = 1'b1;
                d.rdata  = model_rdata;
                d.edge_n = cyc + 1;
            end
            done_exp.push_back(d);
        end
        start = 1'b1; mem_read = rd; mem_write = wr; size = sz; sign_ext = sx;
        addr = a; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0;
        if (ok && !never_ack) begin
            for (int i = 0; i < dly; i++) begin
                if (extra && i == 0) begin
                    start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'b00;
                    addr = $urandom & 32'hFFFF_FFFC;
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
            bus_ack = 1'b1; bus_rdata = brd;
            @(posedge clk); #1;
            bus_ack = 1'b0; bus_rdata = $urandom;
        end
        t = 0;
        while (busy && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("busy_release", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        rd, wr, sx;
        logic [1:0]  sz;
        logic [31:0] a;
        int          pick;
        bus_t        b;

        rst_n = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00;
        sign_ext = 1'b0; addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // lb at byte 3, sign-extended; then sh and lhu at the same halfword.
        do_access(1, 0, 2'b10, 1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 2, 0, 0);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        do_access(0, 1, 2'b01, 0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 1, 0, 0);
        do_access(1, 0, 2'b01, 0, 32'h0000_2002, 32'h0, 32'hABCD_0000, 0, 0, 0);
        check("lhu_rdata", rdata, 32'h0000_ABCD);

        // Misaligned and illegal requests.
        do_access(1, 0, 2'b00, 0, 32'h0000_3002, 32'h0, 32'h0, 0, 0, 0);
        do_access(1, 0, 2'b01, 1, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 0);
        do_access(1, 0, 2'b11, 0, 32'h0000_3000, 32'h0, 32'h0, 0, 0, 0);
        do_access(1, 1, 2'b00, 0, 32'h0000_3000, 32'h0, 32'h0, 0, 0, 0);

        // Timeout on a store; rdata must keep the last load value.
        do_access(0, 1, 2'b00, 0, 32'h0000_4000, 32'h1234_5678, 32'h0, 0, 1, 0);
        check("timeout_rdata_kept", rdata, 32'h0000_ABCD);

        // Start during BUS is ignored; start with neither read nor write does nothing.
        do_access(1, 0, 2'b00, 0, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 4, 0, 1);
        do_access(0, 0, 2'b00, 0, 32'h0000_6000, 32'h0, 32'h0, 0, 0, 0);

        // Reset in the middle of a bus access.
        @(posedge clk); #1;
        b.we = 1'b0; b.addr = 32'h0000_0040; b.be = 4'hF; b.wdata = '0; b.len = 0;
        bus_exp.push_back(b);
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'b00; addr = 32'h0000_0040;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_bus_req", 32'(bus_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        model_rdata = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid_rdata", rdata, 32'd0);
        do_access(1, 0, 2'b00, 0, 32'h0000_0010, 32'h0, 32'h7654_3210, 1, 0, 0);
        check("lw_after_reset", rdata, 32'h7654_3210);

        // Randomized accesses.
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 9);
            rd = (pick == 1) || (pick >= 2 && pick <= 5);
            wr = (pick == 1) || (pick >= 6);
            sz = 2'($urandom_range(0, 3));
            sx = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b00) a = a & 32'hFFFF_FFFC;
                if (sz == 2'b01) a = a & 32'hFFFF_FFFE;
            end
            do_access(rd, wr, sz, sx, a, $urandom, $urandom, $urandom_range(0, 5),
                      $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
        end

        check("bus_queue_drained", 32'(bus_exp.size()), 32'd0);
        check("done_queue_drained", 32'(done_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
